// File: rtl/shift_tx_arbiter.sv
// shift_tx_arbiter: round-robin sharing of one shift_tx_fsm transmitter with ack/timeout and inter-frame gap
module shift_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_WIDTH = 10,
  parameter int TIMEOUT     = 32,
  parameter int GAP_CYCLES  = 2,
  localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   baud_clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_err,
  output logic                   send_en,
  output logic [FRAME_WIDTH-1:0] data_frame,
  input  logic                   frame_sent,
  output logic                   busy,
  output logic [GW-1:0]          grant_id
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int CW = $clog2(FRAME_WIDTH + GAP_CYCLES) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [GW-1:0]          ptr_q, ptr_d, grant_q, grant_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          gap_q, gap_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   send_q, send_d, busy_q;
  logic [NUM_REQ-1:0]     ack_q, ack_d, err_q, err_d;
  logic [NUM_REQ-1:0]     rot;
  logic [GW:0]            off, sum;
  logic [GW-1:0]          gsel, gnext;
  logic                   found;

  // rotate requests so bit 0 is the pointer position; lowest set bit wins
  always_comb begin
    rot   = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    off   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = (GW+1)'(k);
        found = 1'b1;
      end
    end
    sum   = {1'b0, ptr_q} + off;
    gsel  = (sum >= (GW+1)'(NUM_REQ)) ? GW'(sum - (GW+1)'(NUM_REQ)) : GW'(sum);
    gnext = (gsel == GW'(NUM_REQ - 1)) ? '0 : gsel + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    send_d  = 1'b0;
    ack_d   = '0;
    err_d   = '0;
    if (state_q == S_IDLE) begin
      if (found) begin
        frame_d = {{(FRAME_WIDTH-8){1'b1}}, req_data[gsel*8 +: 8]};
        grant_d = gsel;
        ptr_d   = gnext;
        send_d  = 1'b1;
        timer_d = '0;
        state_d = S_WAIT;
      end
    end else if (state_q == S_WAIT) begin
      timer_d = timer_q + 1'b1;
      if (frame_sent) begin
        ack_d[grant_q] = 1'b1;
        gap_d          = CW'(GAP_CYCLES);
        state_d        = S_GAP;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        err_d[grant_q] = 1'b1;
        gap_d          = CW'(GAP_CYCLES);
        state_d        = S_GAP;
      end
    end else begin
      gap_d   = gap_q - 1'b1;
      state_d = (gap_q == CW'(1)) ? S_IDLE : S_GAP;
    end
  end

  // the transmitter has no reset, so reset opens a full-frame flush gap
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GAP;
      ptr_q   <= '0;
      grant_q <= '0;
      timer_q <= '0;
      gap_q   <= CW'(FRAME_WIDTH + GAP_CYCLES);
      frame_q <= '1;
      send_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
      send_q  <= send_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign req_ack    = ack_q;
  assign req_err    = err_q;
  assign send_en    = send_q;
  assign data_frame = frame_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
endmodule

// File: doc/shift_tx_arbiter.md
Name: shift_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one shift_tx_fsm UART transmitter between NUM_REQ byte producers. It grants one pending requester and builds the data frame. It issues a single-cycle send_en, waits for frame_sent, acknowledges or times out, then enforces an idle inter-frame gap. It sits between producers (test-pattern generators, loopback checker, status reporter) and the transmitter, and runs entirely on the baud clock.

Parameters:
NUM_REQ, 4, number of requesters (>=2).
FRAME_WIDTH, 10, width of data_frame; must match transmitter.
TIMEOUT, 32, baud cycles to wait for frame_sent after send_en before aborting (>= FRAME_WIDTH+2).
GAP_CYCLES, 2, idle cycles enforced after each frame (>=1).

Ports:
baud_clk  in  1  baud-rate clock; all logic rising-edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  request pending per requester; held high with req_data stable until ack/err.
req_data  in  NUM_REQ*8  byte per requester, requester i at [8i+7:8i].
req_ack  out  NUM_REQ  one-cycle pulse: requester's frame completed.
req_err  out  NUM_REQ  one-cycle pulse: requester's frame timed out.
send_en  out  1  one-cycle start pulse to transmitter.
data_frame  out  FRAME_WIDTH  frame to transmitter: [7:0]=granted byte (LSB sent first), upper bits all 1.
frame_sent  in  1  completion pulse from transmitter.
busy  out  1  high in every state except IDLE.
grant_id  out  max(1,clog2(NUM_REQ))  index of current/last granted requester.

Behaviour:
- Reset (async assert): req_ack=0, req_err=0, send_en=0, data_frame=all 1s, grant_id=0, rr pointer=0, timer=0, busy=1, state=GAP with gap counter=FRAME_WIDTH+GAP_CYCLES. Because the transmitter has no reset, the line is guaranteed to flush before the first grant.
- All outputs are registered.
- States:
  - IDLE: busy=0. If any req_valid, grant the first valid index searching from rr pointer upward with wrap. On that edge: latch data_frame={1s,req_data[g]}, grant_id<=g, pointer<=(g+1) mod NUM_REQ, send_en<=1, timer<=0, state<=WAIT. If no req_valid, stay in IDLE with no change.
  - WAIT: send_en<=0 (high exactly one cycle). timer increments each cycle.
    - frame_sent=1: req_ack[grant_id]<=1 for one cycle, then GAP.
    - Else if timer==TIMEOUT-1: req_err[grant_id]<=1 for one cycle, then GAP.
    - frame_sent and timeout on the same cycle: ack wins, no err.
  - GAP: counter loaded with GAP_CYCLES on entry. Decrement each cycle; go to IDLE on the cycle the counter reaches 1. This gives exactly GAP_CYCLES cycles in GAP (reset entry uses FRAME_WIDTH+GAP_CYCLES).
- Latency: request seen in IDLE at edge k → send_en high cycle k+1. With the standard transmitter (SHIFT_AMOUNT=8), frame_sent arrives 10 cycles after send_en. req_ack follows one cycle later. The next grant comes earliest GAP_CYCLES cycles after that.
- frame_sent outside WAIT is ignored.
- req_valid dropping before ack does not abort the frame; the latched data is still sent.
- data_frame holds its value until the next grant.
- Arbitration is evaluated only in IDLE; new requests arriving during WAIT/GAP wait their turn.
- A requester that stays valid after ack is not regranted before the others, because the pointer has moved past it.
- Reset mid-WAIT: all state is cleared immediately, no ack/err is issued, and the flush gap applies.

Test Plan:
- Single request, req_valid[0]=1, req_data[7:0]=8'h47 → send_en pulse 1 cycle later, data_frame=10'h347, grant_id=0. After frame_sent, req_ack[0] pulses once and busy=1 for GAP_CYCLES, then 0.
- req_valid=4'b1010 held continuously with acks from a transmitter model → grant order 1,3,1,3. Each ack pulses only its own bit; gaps are exactly 2 cycles.
- All four valid from reset → grants 0,1,2,3,0 in order. The first send_en appears no earlier than FRAME_WIDTH+GAP_CYCLES+1 cycles after rst_n rises.
- frame_sent tied 0, req_valid[2]=1 → req_err[2] pulses exactly 32 cycles after send_en, with no req_ack. The block then regrants requester 2 after the gap.
- frame_sent asserted on the same cycle timer==TIMEOUT-1 → req_ack pulses, req_err stays 0.
- rst_n asserted 4 cycles into WAIT → all outputs take reset values asynchronously and no ack/err appears. After release the first send_en follows the flush gap, and grant restarts from index 0.
